// File: rtl/imem_access_ctrl.sv
// -----------------------------------------------------------------------------
// imem_access_ctrl
//
// Sole owner of the instruction-RAM port. Arbitrates the RAM between the
// boot/program loader (word writes) and the IF stage (word fetches).
//
//   LOAD  : loader owns the RAM, the pipeline is held (cpu_hold=1). Every
//           presented loader word is accepted; aligned in-range words are
//           written, anything else is dropped and flagged in load_err.
//   RUN   : IF stage fetches, one per cycle, result one cycle later.
//   DRAIN : one hold cycle between RUN and LOAD so that the last accepted
//           fetch can return before the loader takes over.
//
// Ports
//   clk, reset           clock, asynchronous active-high reset
//   fetch_req/addr       IF request and byte address
//   fetch_ready          IF request accepted when fetch_req & fetch_ready
//   fetch_valid/instr    fetch result, one cycle after acceptance
//   fetch_misalign       with fetch_valid: accepted address had [1:0] != 0
//   cpu_hold             stall the whole pipeline (LOAD and DRAIN)
//   load_start           request a reload while running
//   load_valid/addr/data loader write word
//   load_ready           loader word accepted when load_valid & load_ready
//   load_done            loader finished, go back to RUN
//   load_count           in-range words written since entering LOAD
//   load_err             sticky: a loader word was dropped
//   mem_addr/we/wdata    synchronous RAM port (word index)
//   mem_rdata            RAM read data, one cycle after a read address
//
// The RAM port is driven combinationally from the accepted request so that a
// synchronous-read RAM can return data in the very next cycle; the RAM port
// is forced idle while reset is asserted so reset never disturbs RAM content.
// -----------------------------------------------------------------------------
module imem_access_ctrl #(
    parameter int          DEPTH     = 1024,
    parameter int          IDX_W     = 10,
    parameter bit          BOOT_LOAD = 1'b1,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             fetch_req,
    input  logic [31:0]      fetch_addr,
    output logic             fetch_ready,
    output logic             fetch_valid,
    output logic [31:0]      fetch_instr,
    output logic             fetch_misalign,

    output logic             cpu_hold,

    input  logic             load_start,
    input  logic             load_valid,
    input  logic [31:0]      load_addr,
    input  logic [31:0]      load_data,
    output logic             load_ready,
    input  logic             load_done,
    output logic [10:0]      load_count,
    output logic             load_err,

    output logic [IDX_W-1:0] mem_addr,
    output logic             mem_we,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam state_t RESET_STATE = BOOT_LOAD ? ST_LOAD : ST_RUN;

    // Word accesses must be aligned and fall inside the RAM.
    function automatic logic addr_ok(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < 32'(DEPTH));
    endfunction

    state_t      state_r;
    state_t      state_nx_s;

    logic        fetch_valid_r;
    logic        fetch_ok_r;
    logic        fetch_misalign_r;
    logic [10:0] load_count_r;
    logic        load_err_r;

    logic        load_go_s;
    logic        fetch_go_s;
    logic        wr_ok_s;
    logic        rd_ok_s;
    logic        rd_mis_s;

    assign wr_ok_s    = addr_ok(load_addr);
    assign rd_ok_s    = addr_ok(fetch_addr);
    assign rd_mis_s   = (fetch_addr[1:0] != 2'b00);
    assign load_go_s  = load_ready & load_valid;
    assign fetch_go_s = fetch_ready & fetch_req;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= RESET_STATE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; load_done only matters in LOAD, load_start only in RUN.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (load_done) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (load_start) begin
                    state_nx_s = ST_DRAIN;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                state_nx_s = ST_LOAD;
            end
            default: begin
                state_nx_s = RESET_STATE;
            end
        endcase
    end

    // State-decoded handshake outputs.
    always_comb begin
        cpu_hold    = 1'b1;
        load_ready  = 1'b0;
        fetch_ready = 1'b0;
        case (state_r)
            ST_LOAD: begin
                cpu_hold   = 1'b1;
                load_ready = 1'b1;
            end
            ST_RUN: begin
                cpu_hold    = 1'b0;
                fetch_ready = 1'b1;
            end
            ST_DRAIN: begin
                cpu_hold = 1'b1;
            end
            default: begin
                cpu_hold = 1'b1;
            end
        endcase
    end

    // RAM port: loader write in LOAD, fetch read in RUN, idle otherwise.
    // load_ready and fetch_ready are mutually exclusive, so a write and a
    // fetch can never share a cycle.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 32'h0000_0000;
        if (reset) begin
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = 32'h0000_0000;
        end else if (load_go_s && wr_ok_s) begin
            mem_we    = 1'b1;
            mem_addr  = load_addr[IDX_W+1:2];
            mem_wdata = load_data;
        end else if (fetch_go_s) begin
            mem_we    = 1'b0;
            mem_addr  = fetch_addr[IDX_W+1:2];
            mem_wdata = 32'h0000_0000;
        end else begin
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = 32'h0000_0000;
        end
    end

    // Fetch return pipeline: one stage, remembers whether the RAM word is usable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_valid_r    <= 1'b0;
            fetch_ok_r       <= 1'b0;
            fetch_misalign_r <= 1'b0;
        end else begin
            fetch_valid_r    <= fetch_go_s;
            fetch_ok_r       <= fetch_go_s & rd_ok_s;
            fetch_misalign_r <= fetch_go_s & rd_mis_s;
        end
    end

    // Loader bookkeeping: cleared on the DRAIN->LOAD transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_count_r <= 11'd0;
            load_err_r   <= 1'b0;
        end else if (state_r == ST_DRAIN) begin
            load_count_r <= 11'd0;
            load_err_r   <= 1'b0;
        end else if (load_go_s) begin
            if (wr_ok_s) begin
                if (load_count_r != 11'd1024) begin
                    load_count_r <= load_count_r + 11'd1;
                end else begin
                    load_count_r <= load_count_r;
                end
            end else begin
                load_err_r <= 1'b1;
            end
        end else begin
            load_count_r <= load_count_r;
            load_err_r   <= load_err_r;
        end
    end

    // RAM data is only forwarded for an aligned in-range fetch; anything else
    // (including no fetch at all) presents the NOP word.
    always_comb begin
        if (fetch_ok_r) begin
            fetch_instr = mem_rdata;
        end else begin
            fetch_instr = NOP_WORD;
        end
    end

    assign fetch_valid    = fetch_valid_r;
    assign fetch_misalign = fetch_misalign_r;
    assign load_count     = load_count_r;
    assign load_err       = load_err_r;

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Testbench for imem_access_ctrl: synchronous RAM model on the memory port,
// a behavioural model of phase/loader bookkeeping and memory contents, and a
// scoreboard that checks every fetch return and every RAM write.
module tb_imem_access_ctrl;

    localparam int M_LOAD  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        fetch_misalign;
    logic        cpu_hold;
    logic        load_start;
    logic        load_valid;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        load_ready;
    logic        load_done;
    logic [10:0] load_count;
    logic        load_err;
    logic [9:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    imem_access_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_req      (fetch_req),
        .fetch_addr     (fetch_addr),
        .fetch_ready    (fetch_ready),
        .fetch_valid    (fetch_valid),
        .fetch_instr    (fetch_instr),
        .fetch_misalign (fetch_misalign),
        .cpu_hold       (cpu_hold),
        .load_start     (load_start),
        .load_valid     (load_valid),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .load_ready     (load_ready),
        .load_done      (load_done),
        .load_count     (load_count),
        .load_err       (load_err),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    // Synchronous-read RAM attached to the DUT.
    logic [31:0] ram [0:1023];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        else        mem_rdata     <= ram[mem_addr];
    end

    // Reference model state.
    logic [31:0] ref_mem [0:1023];
    int mode  = M_LOAD;
    int m_cnt = 0;
    int m_err = 0;
    int cyc   = 0;
    int checks = 0;
    int passed = 0;

    typedef struct { int due; logic [31:0] instr; logic mis; } fexp_t;
    typedef struct { int due; logic [9:0] idx; logic [31:0] data; } wexp_t;
    fexp_t fq[$];
    wexp_t wq[$];
    fexp_t fe;
    wexp_t we_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic bit word_ok(input logic [31:0] a);
        return (a % 4 == 0) && (a / 4 < 1024);
    endfunction

    function automatic logic [31:0] rnd_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0)      return ($urandom_range(0, 1023) * 4) + $urandom_range(1, 3);
        else if (r == 1) return $urandom | 32'h0000_1000;
        else             return $urandom_range(0, 1023) * 4;
    endfunction

    task automatic idle();
        fetch_req = 1'b0; fetch_addr = 32'h0; load_start = 1'b0;
        load_valid = 1'b0; load_addr = 32'h0; load_data = 32'h0; load_done = 1'b0;
    endtask

    // Apply the model for the currently driven inputs, then advance one cycle.
    task automatic step();
        int n_mode, n_cnt, n_err;
        n_mode = mode; n_cnt = m_cnt; n_err = m_err;
        if (mode == M_LOAD) begin
            if (load_valid) begin
                if (word_ok(load_addr)) begin
                    wq.push_back('{due: cyc, idx: 10'(load_addr / 4), data: load_data});
                    ref_mem[load_addr / 4] = load_data;
                    if (n_cnt < 1024) n_cnt++;
                end else begin
                    n_err = 1;
                end
            end
            if (load_done) n_mode = M_RUN;
        end else if (mode == M_RUN) begin
            if (fetch_req)
                fq.push_back('{due: cyc + 1,
                               instr: word_ok(fetch_addr) ? ref_mem[fetch_addr / 4] : 32'h0,
                               mis: (fetch_addr % 4 != 0)});
            if (load_start) n_mode = M_DRAIN;
        end else begin
            n_mode = M_LOAD; n_cnt = 0; n_err = 0;
        end
        @(posedge clk); #1;
        mode = n_mode; m_cnt = n_cnt; m_err = n_err;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        fq.delete(); wq.delete();
        mode = M_LOAD; m_cnt = 0; m_err = 0;
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Monitor: phase outputs, loader counters, fetch returns and RAM writes.
    always @(negedge clk) begin
        chk("cpu_hold",    32'(cpu_hold),    32'(mode != M_RUN));
        chk("load_ready",  32'(load_ready),  32'(mode == M_LOAD));
        chk("fetch_ready", 32'(fetch_ready), 32'(mode == M_RUN));
        chk("load_count",  32'(load_count),  32'(m_cnt));
        chk("load_err",    32'(load_err),    32'(m_err));
        if (fetch_valid) begin
            if (fq.size() > 0 && fq[0].due == cyc) begin
                fe = fq.pop_front();
                chk("fetch_instr",    fetch_instr,          fe.instr);
                chk("fetch_misalign", 32'(fetch_misalign),  32'(fe.mis));
            end else begin
                chk("fetch_valid_unexpected", 32'(fetch_valid), 32'(0));
            end
        end else if (fq.size() > 0 && fq[0].due <= cyc) begin
            chk("fetch_valid_missing", 32'(fetch_valid), 32'(1));
            void'(fq.pop_front());
        end
        if (mem_we) begin
            if (wq.size() > 0 && wq[0].due == cyc) begin
                we_e = wq.pop_front();
                chk("mem_addr",  32'(mem_addr), 32'(we_e.idx));
                chk("mem_wdata", mem_wdata,     we_e.data);
            end else begin
                chk("mem_we_unexpected", 32'(mem_we), 32'(0));
            end
        end else if (wq.size() > 0 && wq[0].due <= cyc) begin
            chk("mem_we_missing", 32'(mem_we), 32'(1));
            void'(wq.pop_front());
        end
    end

    initial begin
        reset = 1'b1;
        idle();
        for (int i = 0; i < 1024; i++) begin
            ram[i]     = $urandom;
            ref_mem[i] = ram[i];
        end
        #2;
        chk("rst_fetch_valid", 32'(fetch_valid),    32'(0));
        chk("rst_fetch_instr", fetch_instr,         32'h0);
        chk("rst_misalign",    32'(fetch_misalign), 32'(0));
        chk("rst_mem_we",      32'(mem_we),         32'(0));
        chk("rst_mem_addr",    32'(mem_addr),       32'(0));
        chk("rst_mem_wdata",   mem_wdata,           32'h0);
        do_reset(3);

        // Directed boot load; second write shares its cycle with load_done.
        load_valid = 1'b1; load_addr = 32'h0; load_data = 32'h2008_0005; step();
        load_addr = 32'h4; load_data = 32'h2009_0003; load_done = 1'b1; step();
        idle();
        chk("boot_count", 32'(load_count), 32'(2));
        chk("boot_hold",  32'(cpu_hold),   32'(0));

        // Back-to-back fetches, out-of-range and misaligned fetches.
        fetch_req = 1'b1;
        fetch_addr = 32'h0;        step();
        fetch_addr = 32'h4;        step();
        fetch_addr = 32'h8;        step();
        fetch_addr = 32'h0000_1000; step();
        fetch_addr = 32'h6;        step();
        // Fetch plus reload request in the same cycle; result returns in DRAIN.
        fetch_addr = 32'h4; load_start = 1'b1; step();
        idle(); step();
        // Dropped writes in the new LOAD phase.
        load_valid = 1'b1; load_addr = 32'h0000_1004; load_data = 32'hdead_beef; step();
        load_addr = 32'h2; step();
        idle(); step();
        chk("drop_err",   32'(load_err),   32'(1));
        chk("drop_count", 32'(load_count), 32'(0));
        load_done = 1'b1; step();

        // Randomized traffic across all phases.
        for (int i = 0; i < 600; i++) begin
            fetch_req  = ($urandom_range(0, 3) != 0);
            fetch_addr = rnd_addr();
            load_valid = $urandom_range(0, 1);
            load_addr  = rnd_addr();
            load_data  = $urandom;
            load_start = ($urandom_range(0, 29) == 0);
            load_done  = ($urandom_range(0, 14) == 0);
            step();
        end

        // Get back to RUN, then reset with a fetch in flight.
        for (int i = 0; i < 4 && mode != M_RUN; i++) begin
            idle(); load_done = 1'b1; step();
        end
        idle(); fetch_req = 1'b1; fetch_addr = 32'h4; step();
        do_reset(2);
        idle();
        chk("midfetch_valid", 32'(fetch_valid), 32'(0));

        // Reset in the middle of a LOAD phase with load_err set.
        load_valid = 1'b1; load_addr = 32'h2; step();
        idle(); step();
        chk("midload_err_set", 32'(load_err), 32'(1));
        do_reset(2);
        chk("midload_err_clr", 32'(load_err), 32'(0));
        chk("midload_hold",    32'(cpu_hold), 32'(1));

        // Count saturation.
        for (int i = 0; i < 1030; i++) begin
            load_valid = 1'b1; load_addr = (i % 1024) * 4; load_data = $urandom; step();
        end
        idle(); step();
        chk("sat_count", 32'(load_count), 32'(1024));
        load_done = 1'b1; step();
        idle();
        for (int i = 0; i < 20; i++) begin
            fetch_req = 1'b1; fetch_addr = $urandom_range(0, 1023) * 4; step();
        end
        idle(); step(); step();
        chk("fq_drained", 32'(fq.size()), 32'(0));
        chk("wq_drained", 32'(wq.size()), 32'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
